// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing from the 25 MHz pixel clock.
// Ports: clk, rst (sync, active-high) -> h_cnt, v_cnt, hsync, vsync,
//   valid, line_start, frame_start. `VGA_SYNC_DELAY_EN delays the
//   decoded outputs by one clock relative to h_cnt/v_cnt.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hsync,
  output logic       vsync,
  output logic       valid,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must be <= 1024");
  end

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  localparam logic [9:0] H_B1 = 10'(H_ACTIVE);
  localparam logic [9:0] H_B2 = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_B3 = 10'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [9:0] V_B1 = 10'(V_ACTIVE);
  localparam logic [9:0] V_B2 = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_B3 = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    P_ACTIVE,
    P_FP,
    P_SYNC,
    P_BP
  } phase_t;

  // Ranges are disjoint so an empty porch simply never matches.
  function automatic phase_t region(
    input logic [9:0] c,
    input logic [9:0] b1,
    input logic [9:0] b2,
    input logic [9:0] b3
  );
    phase_t r;
    r = P_BP;
    unique case (1'b1)
      (c < b1):             r = P_ACTIVE;
      (c >= b1 && c < b2):  r = P_FP;
      (c >= b2 && c < b3):  r = P_SYNC;
      default:              r = P_BP;
    endcase
    return r;
  endfunction

  localparam phase_t H_RST = region(H_LAST, H_B1, H_B2, H_B3);
  localparam phase_t V_RST = region(V_LAST, V_B1, V_B2, V_B3);

  phase_t     h_st, h_st_nxt;
  phase_t     v_st, v_st_nxt;
  logic [9:0] h_nxt, v_nxt;
  logic       h_wrap;

  logic hsync_d, vsync_d, valid_d, ls_d, fs_d;
  logic hsync_q, vsync_q, valid_q, ls_q, fs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt   <= H_LAST;
      v_cnt   <= V_LAST;
      h_st    <= H_RST;
      v_st    <= V_RST;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      valid_q <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      h_cnt   <= h_nxt;
      v_cnt   <= v_nxt;
      h_st    <= h_st_nxt;
      v_st    <= v_st_nxt;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      valid_q <= valid_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

  // Outputs decode the values being loaded, so after the edge they
  // describe the pixel now on h_cnt/v_cnt.
  always_comb begin
    h_wrap   = (h_cnt == H_LAST);
    h_nxt    = h_cnt + 10'd1;
    v_nxt    = v_cnt;
    h_st_nxt = region(h_nxt, H_B1, H_B2, H_B3);
    v_st_nxt = v_st;
    if (h_wrap) begin
      h_nxt    = 10'd0;
      h_st_nxt = P_ACTIVE;
      v_nxt    = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      v_st_nxt = region(v_nxt, V_B1, V_B2, V_B3);
    end
    hsync_d = (h_st_nxt != P_SYNC);
    vsync_d = (v_st_nxt != P_SYNC);
    valid_d = (h_st_nxt == P_ACTIVE) && (v_st_nxt == P_ACTIVE);
    ls_d    = (h_nxt == 10'd0);
    fs_d    = (h_nxt == 10'd0) && (v_nxt == 10'd0);
  end

`ifdef VGA_SYNC_DELAY_EN
  logic hsync_p, vsync_p, valid_p, ls_p, fs_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_p <= 1'b1;
      vsync_p <= 1'b1;
      valid_p <= 1'b0;
      ls_p    <= 1'b0;
      fs_p    <= 1'b0;
    end else begin
      hsync_p <= hsync_q;
      vsync_p <= vsync_q;
      valid_p <= valid_q;
      ls_p    <= ls_q;
      fs_p    <= fs_q;
    end
  end

  assign hsync       = hsync_p;
  assign vsync       = vsync_p;
  assign valid       = valid_p;
  assign line_start  = ls_p;
  assign frame_start = fs_p;
`else
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign valid       = valid_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of default and reduced timing.
// Shares clk/rst between a default instance and a tiny-raster instance.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_DELAY_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #20 clk = ~clk;

  logic [9:0] h_cnt, v_cnt;
  logic hsync, vsync, valid, line_start, frame_start;
  logic [9:0] sh, sv;
  logic shs, svs, sva, sls, sfs;

  vga_timing_gen dut (
    .clk(clk), .rst(rst),
    .h_cnt(h_cnt), .v_cnt(v_cnt),
    .hsync(hsync), .vsync(vsync), .valid(valid),
    .line_start(line_start), .frame_start(frame_start)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_s (
    .clk(clk), .rst(rst),
    .h_cnt(sh), .v_cnt(sv),
    .hsync(shs), .vsync(svs), .valid(sva),
    .line_start(sls), .frame_start(sfs)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_rst_outs(input string tag);
    chk({tag, "_h"}, h_cnt, 799);
    chk({tag, "_v"}, v_cnt, 524);
    chk({tag, "_hs"}, hsync, 1);
    chk({tag, "_vs"}, vsync, 1);
    chk({tag, "_va"}, valid, 0);
    chk({tag, "_ls"}, line_start, 0);
    chk({tag, "_fs"}, frame_start, 0);
  endtask

  int h_bad, v_bad, hs_n, hs_f, va_n, va_last, ls_n;
  int fs_n, ls2_n, vs_n, vs_f, va2_n, va_bad, hs2_n, hs2_f;
  int fs_at[2];
  int ls_at[2];

  initial begin
    rst = 1'b1;
    tick(3);
    chk_rst_outs("rst_hold");
    chk("rst_small_h", sh, 11);
    chk("rst_small_v", sv, 6);
    chk("rst_small_va", sva, 0);

    rst = 1'b0;
    tick(1);
    chk("rel_h", h_cnt, 0);
    chk("rel_v", v_cnt, 0);
    chk("rel_va", valid, LAT == 0);
    chk("rel_ls", line_start, LAT == 0);
    chk("rel_fs", frame_start, LAT == 0);
    chk("rel_hs", hsync, 1);

    h_bad = 0; v_bad = 0; hs_n = 0; hs_f = -1;
    va_n = 0; va_last = -1; ls_n = 0;
    for (int i = 0; i < 800; i++) begin
      if (i > 0) tick(1);
      if (h_cnt != 10'(i)) h_bad++;
      if (v_cnt != 10'd0) v_bad++;
      if (!hsync) begin
        hs_n++;
        if (hs_f < 0) hs_f = i;
      end
      if (valid) begin
        va_n++;
        va_last = i;
      end
      if (line_start) ls_n++;
    end
    chk("line_h_seq_err", h_bad, 0);
    chk("line_v_hold_err", v_bad, 0);
    chk("line_hs_low_n", hs_n, 96);
    chk("line_hs_first", hs_f, 656 + LAT);
    chk("line_va_n", va_n, 640);
    chk("line_va_last", va_last, 639 + LAT);
    chk("line_ls_n", ls_n, 1);

    tick(1);
    chk("wrap_h", h_cnt, 0);
    chk("wrap_v", v_cnt, 1);
    chk("wrap_ls", line_start, LAT == 0);
    chk("wrap_fs", frame_start, 0);

    tick(300);
    chk("mid_h", h_cnt, 300);
    chk("mid_v", v_cnt, 1);
    rst = 1'b1;
    tick(1);
    chk_rst_outs("mid_rst");
    rst = 1'b0;
    tick(1);
    chk("resume_h", h_cnt, 0);
    chk("resume_v", v_cnt, 0);
    chk("resume_fs", frame_start, LAT == 0);
    tick(1);
    chk("resume1_h", h_cnt, 1);
    chk("resume1_fs", frame_start, LAT == 1);

    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    chk("sm_start_h", sh, 0);
    chk("sm_start_v", sv, 0);

    fs_n = 0; ls2_n = 0; vs_n = 0; vs_f = -1;
    va2_n = 0; va_bad = 0; hs2_n = 0; hs2_f = -1;
    fs_at[0] = -1; fs_at[1] = -1;
    ls_at[0] = -1; ls_at[1] = -1;
    for (int k = 0; k < 168; k++) begin
      if (k > 0) tick(1);
      if (sfs) begin
        if (fs_n < 2) fs_at[fs_n] = k;
        fs_n++;
      end
      if (k < 84) begin
        if (sls) begin
          if (ls2_n < 2) ls_at[ls2_n] = k;
          ls2_n++;
        end
        if (!svs) begin
          vs_n++;
          if (vs_f < 0) vs_f = k;
        end
        if (sva) va2_n++;
        if (sva && sv >= 10'd4) va_bad++;
      end
      if (k < 12 && !shs) begin
        hs2_n++;
        if (hs2_f < 0) hs2_f = k;
      end
    end
    chk("sm_fs_n", fs_n, 2);
    chk("sm_fs_first", fs_at[0], LAT);
    chk("sm_frame_period", fs_at[1] - fs_at[0], 84);
    chk("sm_ls_n", ls2_n, 7);
    chk("sm_line_period", ls_at[1] - ls_at[0], 12);
    chk("sm_hs_low_n", hs2_n, 2);
    chk("sm_hs_first", hs2_f, 9 + LAT);
    chk("sm_vs_low_n", vs_n, 12);
    chk("sm_vs_first", vs_f, 60 + LAT);
    chk("sm_va_n", va2_n, 32);
    chk("sm_va_vblank", va_bad, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
